frame_tracker: RTL
==================

Name: frame_tracker

Overview:
- Parametrised successor to the AXI-Stream frame control FSM; sits directly behind the ingress beat-accept logic (beat_accept = tvalid && tready).
- Tracks frame boundaries and the header/payload split by counting beats internally (HDR_BEATS), replacing the external header_done strobe.
- Adds per-frame beat counting, runt detection, truncated-header detection and oversize detection with discard-until-tlast.
- Downstream parser and stats blocks consume its registered region flags, beat index, length and error pulses.

Parameters:
- HDR_BEATS, 2, number of header beats per frame; must be >= 1.
- MIN_BEATS, 3, minimum legal frame length in beats; must be >= 1 and <= MAX_BEATS.
- MAX_BEATS, 64, maximum legal frame length in beats; must be > HDR_BEATS.
- CNT_W, $clog2(MAX_BEATS+1), width of the beat counter and length outputs (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- beat_accept  in  1  a beat is transferred this cycle.
- tlast  in  1  last beat of frame; sampled only when beat_accept=1.
- frame_start  out  1  one-cycle pulse after the first beat of a frame is accepted.
- frame_end  out  1  one-cycle pulse after the tlast beat is accepted.
- in_header  out  1  next beat belongs to the header.
- in_payload  out  1  next beat belongs to the payload.
- in_drop  out  1  frame is oversize; remaining beats are being discarded.
- beat_idx  out  CNT_W  index of the next beat within the current frame; 0 in IDLE; saturates at MAX_BEATS.
- frame_len  out  CNT_W  beat count of the completed frame; valid while frame_end=1; held otherwise.
- frame_drop  out  1  qualifies frame_end: the frame was dropped (oversize).
- err_runt  out  1  pulse with frame_end when frame length < MIN_BEATS.
- err_trunc  out  1  pulse with frame_end when tlast arrives before HDR_BEATS beats.
- err_oversize  out  1  pulse on the edge that accepts beat MAX_BEATS without tlast.

Behaviour:
- All outputs are registered. Latency is 1 cycle: every response appears in the cycle after the accepting edge.
- Reset (rst=1 at an edge): state=IDLE and every output = 0, including frame_len. Reset overrides any beat in the same cycle. Reset mid-frame abandons the frame with no frame_end pulse.
- Cycles with beat_accept=0 change nothing; pulses clear to 0 and state and counters hold.
- Let n = beat_idx+1, the count of beats accepted so far including the current one.
- IDLE, on an accepted beat:
  - frame_start=1.
  - If tlast=1: single-beat frame; frame_end=1, frame_len=1; stay IDLE.
  - Else: go to HEADER if HDR_BEATS>1, otherwise PAYLOAD.
- HEADER, on an accepted beat:
  - If tlast=1: go to IDLE; frame_end=1, err_trunc=1.
  - Else if n==HDR_BEATS: go to PAYLOAD.
- PAYLOAD, on an accepted beat:
  - If tlast=1: go to IDLE; frame_end=1.
  - Else if n==MAX_BEATS: go to DROP; err_oversize=1.
  - A frame of exactly MAX_BEATS beats is legal.
- DROP, on an accepted beat:
  - Beats are ignored and beat_idx holds at MAX_BEATS.
  - tlast=1 goes to IDLE with frame_end=1, frame_drop=1, frame_len=MAX_BEATS.
- At every frame_end:
  - frame_len=n, saturated at MAX_BEATS.
  - err_runt = (n < MIN_BEATS) and not dropped.
  - err_trunc also applies to a single-beat frame when HDR_BEATS>1.
  - Pulses clear to 0 on the next cycle.
- Region flags: in_header = (state==HEADER), in_payload = (state==PAYLOAD), in_drop = (state==DROP). At most one is high; all are 0 in IDLE.
- Back-to-back frames: a beat accepted in the cycle after a frame's tlast beat starts a new frame. frame_end of A and frame_start of B appear in consecutive cycles, with no idle beat required.
- The beat counter never wraps; it saturates at MAX_BEATS.

Test Plan (HDR_BEATS=2, MIN_BEATS=3, MAX_BEATS=6):
- 5-beat frame, with tlast on beat 4:
  - after beat 0: frame_start=1, in_header=1, beat_idx=1;
  - after beat 1: in_payload=1;
  - after beat 4: frame_end=1, frame_len=5, all errors 0, state IDLE.
- 1-beat frame (tlast on beat 0): frame_start=frame_end=1 in the same cycle, frame_len=1, err_trunc=1, err_runt=1, in_header=in_payload=0.
- 6-beat frame: frame_len=6 and no err_oversize.
- 9-beat frame:
  - after beat 5: err_oversize=1, in_drop=1;
  - beats 6-7: no outputs change;
  - after beat 8: frame_end=1, frame_drop=1, frame_len=6, err_runt=0.
- Three 3-beat frames with beat_accept held high: frame_end/frame_start alternate in consecutive cycles, each frame_len=3, no errors.
- Gaps and reset:
  - a 4-beat frame with 2 idle cycles between beats matches the gapless result (frame_len=4);
  - rst=1 after beat 2 of a frame: all outputs 0, no frame_end;
  - the next beat raises frame_start.

Source files
------------

// File: rtl/frame_tracker_if.sv
// frame_tracker_if: beat-accept inputs and frame-tracking outputs of frame_tracker
interface frame_tracker_if #(
  parameter int CNT_W = 7
);
  logic             beat_accept;
  logic             tlast;
  logic             frame_start;
  logic             frame_end;
  logic             in_header;
  logic             in_payload;
  logic             in_drop;
  logic [CNT_W-1:0] beat_idx;
  logic [CNT_W-1:0] frame_len;
  logic             frame_drop;
  logic             err_runt;
  logic             err_trunc;
  logic             err_oversize;
  modport master (
    output beat_accept, tlast,
    input  frame_start, frame_end, in_header, in_payload, in_drop,
           beat_idx, frame_len, frame_drop, err_runt, err_trunc, err_oversize
  );
  modport slave (
    input  beat_accept, tlast,
    output frame_start, frame_end, in_header, in_payload, in_drop,
           beat_idx, frame_len, frame_drop, err_runt, err_trunc, err_oversize
  );
endinterface

// File: rtl/frame_tracker.sv
// frame_tracker: frame boundary, header/payload region and length/error tracking for an accepted beat stream
module frame_tracker #(
  parameter int HDR_BEATS = 2,
  parameter int MIN_BEATS = 3,
  parameter int MAX_BEATS = 64,
  parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input logic            clk,
  input logic            rst,
  frame_tracker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;
  // n is one bit wider so that the count past MAX_BEATS in DROP cannot wrap
  localparam logic [CNT_W:0]   HDR_N = (CNT_W + 1)'(HDR_BEATS);
  localparam logic [CNT_W:0]   MIN_N = (CNT_W + 1)'(MIN_BEATS);
  localparam logic [CNT_W:0]   MAX_N = (CNT_W + 1)'(MAX_BEATS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_BEATS);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_idx_q, beat_idx_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             frame_drop_q, frame_drop_d;
  logic             err_runt_q, err_runt_d;
  logic             err_trunc_q, err_trunc_d;
  logic             err_oversize_q, err_oversize_d;
  logic [CNT_W:0]   n;
  logic [CNT_W-1:0] n_sat;
  // next state, beat counter and one-cycle pulses for the beat accepted this cycle
  always_comb begin
    n              = {1'b0, beat_idx_q} + 1'b1;
    n_sat          = n > MAX_N ? MAX_C : n[CNT_W-1:0];
    state_d        = state_q;
    beat_idx_d     = beat_idx_q;
    frame_len_d    = frame_len_q;
    frame_start_d  = 1'b0;
    frame_end_d    = 1'b0;
    frame_drop_d   = 1'b0;
    err_runt_d     = 1'b0;
    err_trunc_d    = 1'b0;
    err_oversize_d = 1'b0;
    if (bus.beat_accept) begin
      frame_start_d = state_q == IDLE;
      if (bus.tlast) begin
        state_d      = IDLE;
        beat_idx_d   = '0;
        frame_end_d  = 1'b1;
        frame_len_d  = n_sat;
        frame_drop_d = state_q == DROP;
        err_runt_d   = n < MIN_N && state_q != DROP;
        err_trunc_d  = state_q == HEADER || (state_q == IDLE && HDR_BEATS > 1);
      end else begin
        beat_idx_d     = n_sat;
        err_oversize_d = state_q == PAYLOAD && n == MAX_N;
        state_d        = state_q == IDLE ? (HDR_BEATS > 1 ? HEADER : PAYLOAD) :
                         state_q == HEADER && n == HDR_N ? PAYLOAD :
                         err_oversize_d ? DROP : state_q;
      end
    end
  end
  // state and output registers; reset abandons any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_idx_q     <= '0;
      frame_len_q    <= '0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_drop_q   <= 1'b0;
      err_runt_q     <= 1'b0;
      err_trunc_q    <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_idx_q     <= beat_idx_d;
      frame_len_q    <= frame_len_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      frame_drop_q   <= frame_drop_d;
      err_runt_q     <= err_runt_d;
      err_trunc_q    <= err_trunc_d;
      err_oversize_q <= err_oversize_d;
    end
  end
  assign bus.frame_start  = frame_start_q;
  assign bus.frame_end    = frame_end_q;
  assign bus.in_header    = state_q == HEADER;
  assign bus.in_payload   = state_q == PAYLOAD;
  assign bus.in_drop      = state_q == DROP;
  assign bus.beat_idx     = beat_idx_q;
  assign bus.frame_len    = frame_len_q;
  assign bus.frame_drop   = frame_drop_q;
  assign bus.err_runt     = err_runt_q;
  assign bus.err_trunc    = err_trunc_q;
  assign bus.err_oversize = err_oversize_q;
endmodule
